orb_bank_scheduler: RTL and testbench

Ping-pong controller for the two orbit frame buffers. The frame filler writes one 1024-word bank while the serializer reads the other. The scheduler routes the filler's write port and the serializer's read requests to the correct bank and toggles `orbSwitch` to start each new fill. At a frame boundary it swaps the banks, or repeats the current read frame if the fill is late.

---
 rtl/orb_bank_scheduler.sv | 163 ++++++++++++++++
 tb/tb_orb_bank_scheduler.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/orb_bank_scheduler.sv
// Ping-pong scheduler for the two orbit frame buffers.
// The filler writes the bank selected by fill_bank_o while the serializer reads the other one.
// At each frame end the banks swap if the fill has completed; otherwise the read frame repeats.
//
// Ports:
//   clk_i, reset_i            clock, synchronous active-high reset
//   wr_data_i/wr_addr_i/wr_en_i  filler write port
//   orb_switch_o              level toggle, each edge starts one filler frame
//   rd_req_i                  serializer word request
//   rd_data_o/rd_valid_o      read word and its strobe (3-cycle latency)
//   frame_start_o             strobe with rd_valid_o for address 0
//   primed_o                  first complete frame has been swapped in
//   fill_bank_o               bank owned by the filler
//   underrun_cnt_o            saturating count of repeated frames
//   ram{0,1}_addr_o/data_o/we_o  registered bank ports
//   ram{0,1}_q_i              bank read data, one-cycle latency
module orb_bank_scheduler #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 12
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              wr_en_i,
  output logic              orb_switch_o,
  input  logic              rd_req_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              frame_start_o,
  output logic              primed_o,
  output logic              fill_bank_o,
  output logic [7:0]        underrun_cnt_o,
  output logic [ADDR_W-1:0] ram0_addr_o,
  output logic [ADDR_W-1:0] ram1_addr_o,
  output logic [DATA_W-1:0] ram0_data_o,
  output logic [DATA_W-1:0] ram1_data_o,
  output logic              ram0_we_o,
  output logic              ram1_we_o,
  input  logic [DATA_W-1:0] ram0_q_i,
  input  logic [DATA_W-1:0] ram1_q_i
);

  typedef enum logic [1:0] {StInit, StKick, StRun} state_e;

  state_e              state_q;
  logic                orb_switch_q, fill_bank_q, fill_done_q, primed_q, wr_en_prev_q;
  logic [ADDR_W-1:0]   rd_ptr_q;
  logic [7:0]          underrun_cnt_q;
  logic [ADDR_W-1:0]   ram0_addr_q, ram1_addr_q;
  logic [DATA_W-1:0]   ram0_data_q, ram1_data_q;
  logic                ram0_we_q, ram1_we_q;
  // Read pipeline: bank select, zero-force and frame-start travel with each request.
  logic                s1_valid_q, s1_bank_q, s1_zero_q, s1_first_q;
  logic                s2_valid_q, s2_bank_q, s2_zero_q, s2_first_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_valid_q, frame_start_q;

  logic last_req, fill_done_set, swap;

  always_comb begin
    last_req      = rd_req_i && (rd_ptr_q == {ADDR_W{1'b1}});
    // Falling edge of wr_en on the last address marks a complete fill.
    fill_done_set = wr_en_prev_q && !wr_en_i && (wr_addr_i == {ADDR_W{1'b1}});
    swap          = last_req && (fill_done_q || fill_done_set);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= StInit;
      orb_switch_q   <= 1'b0;
      fill_bank_q    <= 1'b0;
      fill_done_q    <= 1'b0;
      primed_q       <= 1'b0;
      wr_en_prev_q   <= 1'b0;
      rd_ptr_q       <= '0;
      underrun_cnt_q <= '0;
      ram0_addr_q    <= '0;
      ram1_addr_q    <= '0;
      ram0_data_q    <= '0;
      ram1_data_q    <= '0;
      ram0_we_q      <= 1'b0;
      ram1_we_q      <= 1'b0;
      s1_valid_q     <= 1'b0;
      s1_bank_q      <= 1'b0;
      s1_zero_q      <= 1'b0;
      s1_first_q     <= 1'b0;
      s2_valid_q     <= 1'b0;
      s2_bank_q      <= 1'b0;
      s2_zero_q      <= 1'b0;
      s2_first_q     <= 1'b0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      frame_start_q  <= 1'b0;
    end else begin
      state_q <= (state_q == StInit) ? StKick : StRun;
      // Entering KICK starts the first fill; every swap starts the next one.
      orb_switch_q <= orb_switch_q ^ ((state_q == StInit) || swap);
      wr_en_prev_q <= wr_en_i;

      if (swap) begin
        fill_bank_q <= ~fill_bank_q;
        fill_done_q <= 1'b0;
        primed_q    <= 1'b1;
      end else if (fill_done_set) begin
        fill_done_q <= 1'b1;
      end

      if (last_req && !swap && primed_q && (underrun_cnt_q != 8'hFF)) begin
        underrun_cnt_q <= underrun_cnt_q + 8'd1;
      end

      if (rd_req_i) begin
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end

      // The read bank is never written: it always gets the read pointer with we low.
      if (fill_bank_q) begin
        ram1_addr_q <= wr_addr_i;
        ram1_data_q <= wr_data_i;
        ram1_we_q   <= wr_en_i;
        ram0_addr_q <= rd_ptr_q;
        ram0_data_q <= '0;
        ram0_we_q   <= 1'b0;
      end else begin
        ram0_addr_q <= wr_addr_i;
        ram0_data_q <= wr_data_i;
        ram0_we_q   <= wr_en_i;
        ram1_addr_q <= rd_ptr_q;
        ram1_data_q <= '0;
        ram1_we_q   <= 1'b0;
      end

      s1_valid_q <= rd_req_i;
      s1_bank_q  <= ~fill_bank_q;
      s1_zero_q  <= ~primed_q;
      s1_first_q <= (rd_ptr_q == '0);
      s2_valid_q <= s1_valid_q;
      s2_bank_q  <= s1_bank_q;
      s2_zero_q  <= s1_zero_q;
      s2_first_q <= s1_first_q;

      rd_valid_q    <= s2_valid_q;
      frame_start_q <= s2_valid_q && s2_first_q;
      rd_data_q     <= (s2_valid_q && !s2_zero_q) ? (s2_bank_q ? ram1_q_i : ram0_q_i) : '0;
    end
  end

  assign orb_switch_o   = orb_switch_q;
  assign rd_data_o      = rd_data_q;
  assign rd_valid_o     = rd_valid_q;
  assign frame_start_o  = frame_start_q;
  assign primed_o       = primed_q;
  assign fill_bank_o    = fill_bank_q;
  assign underrun_cnt_o = underrun_cnt_q;
  assign ram0_addr_o    = ram0_addr_q;
  assign ram1_addr_o    = ram1_addr_q;
  assign ram0_data_o    = ram0_data_q;
  assign ram1_data_o    = ram1_data_q;
  assign ram0_we_o      = ram0_we_q;
  assign ram1_we_o      = ram1_we_q;

endmodule

// File: tb/tb_orb_bank_scheduler.sv
// Directed bench for orb_bank_scheduler with two behavioural 1024x12 synchronous RAMs.
module tb_orb_bank_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] wr_data;
  logic [9:0]  wr_addr;
  logic        wr_en;
  logic        orb_switch;
  logic        rd_req;
  logic [11:0] rd_data;
  logic        rd_valid;
  logic        frame_start;
  logic        primed;
  logic        fill_bank;
  logic [7:0]  underrun_cnt;
  logic [9:0]  ram0_addr, ram1_addr;
  logic [11:0] ram0_data, ram1_data;
  logic        ram0_we, ram1_we;
  logic [11:0] ram0_q, ram1_q;

  logic [11:0] mem0 [1024];
  logic [11:0] mem1 [1024];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ram0_we) mem0[ram0_addr] <= ram0_data;
    if (ram1_we) mem1[ram1_addr] <= ram1_data;
    ram0_q <= mem0[ram0_addr];
    ram1_q <= mem1[ram1_addr];
  end

  orb_bank_scheduler #(.ADDR_W(10), .DATA_W(12)) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .wr_data_i      (wr_data),
    .wr_addr_i      (wr_addr),
    .wr_en_i        (wr_en),
    .orb_switch_o   (orb_switch),
    .rd_req_i       (rd_req),
    .rd_data_o      (rd_data),
    .rd_valid_o     (rd_valid),
    .frame_start_o  (frame_start),
    .primed_o       (primed),
    .fill_bank_o    (fill_bank),
    .underrun_cnt_o (underrun_cnt),
    .ram0_addr_o    (ram0_addr),
    .ram1_addr_o    (ram1_addr),
    .ram0_data_o    (ram0_data),
    .ram1_data_o    (ram1_data),
    .ram0_we_o      (ram0_we),
    .ram1_we_o      (ram1_we),
    .ram0_q_i       (ram0_q),
    .ram1_q_i       (ram1_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_orb"},    32'(orb_switch),   0);
    chk({tag, "_rdata"},  32'(rd_data),      0);
    chk({tag, "_rvalid"}, 32'(rd_valid),     0);
    chk({tag, "_fs"},     32'(frame_start),  0);
    chk({tag, "_primed"}, 32'(primed),       0);
    chk({tag, "_fbank"},  32'(fill_bank),    0);
    chk({tag, "_urun"},   32'(underrun_cnt), 0);
    chk({tag, "_r0a"},    32'(ram0_addr),    0);
    chk({tag, "_r1a"},    32'(ram1_addr),    0);
    chk({tag, "_r0d"},    32'(ram0_data),    0);
    chk({tag, "_r1d"},    32'(ram1_data),    0);
    chk({tag, "_r0we"},   32'(ram0_we),      0);
    chk({tag, "_r1we"},   32'(ram1_we),      0);
  endtask

  initial begin
    reset = 1'b1; wr_data = '0; wr_addr = '0; wr_en = 1'b0; rd_req = 1'b0;

    // Reset release and kick
    repeat (4) tick();
    chk_reset("rst");
    reset = 1'b0;
    tick();
    chk("kick_orb", 32'(orb_switch), 1);
    chk("kick_fbank", 32'(fill_bank), 0);
    tick();
    tick();

    // Unprimed reads: data forced to zero, valid 3 cycles after each request
    for (int i = 0; i < 8; i++) begin
      rd_req = (i < 4);
      chk("unp_valid", 32'(rd_valid), 32'(i >= 3 && i < 7));
      chk("unp_data", 32'(rd_data), 0);
      chk("unp_fs", 32'(frame_start), 32'(i == 3));
      tick();
    end

    // Finish an unprimed frame without a fill: repeat, but no underrun counted
    rd_req = 1'b1;
    repeat (1020) tick();
    rd_req = 1'b0;
    repeat (4) tick();
    chk("unp_urun", 32'(underrun_cnt), 0);
    chk("unp_primed", 32'(primed), 0);
    chk("unp_fbank", 32'(fill_bank), 0);
    chk("unp_orb", 32'(orb_switch), 1);

    // Fill bank 0 with data = address, wr_en held 3 cycles per word
    for (int a = 0; a < 1024; a++) begin
      wr_addr = 10'(a);
      wr_data = 12'(a);
      wr_en   = 1'b1;
      tick();
      if (a == 5) begin
        chk("fill_r0a", 32'(ram0_addr), 5);
        chk("fill_r0d", 32'(ram0_data), 5);
        chk("fill_r0we", 32'(ram0_we), 1);
        chk("fill_r1we", 32'(ram1_we), 0);
      end
      tick();
      tick();
    end
    wr_en = 1'b0;
    tick();
    tick();
    chk("filled_fbank", 32'(fill_bank), 0);
    chk("filled_orb", 32'(orb_switch), 1);

    // One full frame of reads (ptr 0..1023): swap at the last request
    rd_req = 1'b1;
    repeat (1024) tick();
    chk("swap_fbank", 32'(fill_bank), 1);
    chk("swap_orb", 32'(orb_switch), 0);
    chk("swap_primed", 32'(primed), 1);
    chk("swap_urun", 32'(underrun_cnt), 0);

    // Primed frame from bank 0 while the filler stalls at address 500 -> underrun
    for (int i = 0; i <= 1030; i++) begin
      rd_req  = (i < 1028);
      wr_en   = (i <= 500);
      wr_addr = (i <= 500) ? 10'(i) : 10'd500;
      wr_data = 12'(((i <= 500) ? i : 500) + 1024);
      chk("frm_valid", 32'(rd_valid), 1);
      chk("frm_data", 32'(rd_data), (i < 3) ? 0 : 32'((i - 3) % 1024));
      chk("frm_fs", 32'(frame_start), 32'(i == 3 || i == 1027));
      if (i == 10) begin
        chk("rt_r1a", 32'(ram1_addr), 9);
        chk("rt_r1d", 32'(ram1_data), 32'h409);
        chk("rt_r1we", 32'(ram1_we), 1);
        chk("rt_r0a", 32'(ram0_addr), 9);
        chk("rt_r0we", 32'(ram0_we), 0);
      end
      tick();
    end
    chk("urun_cnt", 32'(underrun_cnt), 1);
    chk("urun_fbank", 32'(fill_bank), 1);
    chk("urun_orb", 32'(orb_switch), 0);

    // Fill completion lands on the same cycle as the ptr 1023 request
    rd_req = 1'b1;
    repeat (496) tick();
    for (int j = 0; j < 524; j++) begin
      wr_en   = (j < 523);
      wr_addr = (j < 523) ? 10'(501 + j) : 10'd1023;
      wr_data = 12'(((j < 523) ? 501 + j : 1023) + 1024);
      if (j == 523) chk("sim_pre_fbank", 32'(fill_bank), 1);
      tick();
    end
    wr_en = 1'b0;
    chk("sim_fbank", 32'(fill_bank), 0);
    chk("sim_orb", 32'(orb_switch), 1);
    chk("sim_urun", 32'(underrun_cnt), 1);

    // Read bank 1 up to ptr 300
    for (int k = 0; k < 300; k++) begin
      if (k >= 3) begin
        chk("b1_valid", 32'(rd_valid), 1);
        chk("b1_data", 32'(rd_data), 32'(1024 + k - 3));
        chk("b1_fs", 32'(frame_start), 32'(k == 3));
      end
      tick();
    end

    // Mid-frame reset with reads in flight
    reset = 1'b1;
    tick();
    rd_req = 1'b0;
    chk_reset("mid");
    tick();
    chk("mid2_valid", 32'(rd_valid), 0);
    reset = 1'b0;
    tick();
    chk("re_kick_orb", 32'(orb_switch), 1);
    chk("re_kick_valid", 32'(rd_valid), 0);
    tick();
    chk("re_valid", 32'(rd_valid), 0);
    chk("re_primed", 32'(primed), 0);
    chk("re_fbank", 32'(fill_bank), 0);
    chk("re_urun", 32'(underrun_cnt), 0);
    tick();
    chk("re_valid2", 32'(rd_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
